// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
//
// Fetch stage for the Fetch & Decode path: a run-time programmable instruction
// memory with an integrated program counter and a registered (one-cycle) read.
// Each cycle the decoder sees a (pc_out, instr, instr_valid) triple.
//
// Parameters
//   DATA_W   : instruction word width in bits
//   DEPTH    : number of instruction words (any value, not only powers of 2)
//   ADDR_W   : word-address width, 2**ADDR_W >= DEPTH
//   RESET_PC : word address loaded into the PC on reset, < DEPTH
//
// Ports
//   clk            : system clock, all state changes on the rising edge
//   reset          : synchronous, active-high reset (memory is not cleared)
//   prog_we        : programming-port write enable
//   prog_addr      : programming-port word address (>= DEPTH is dropped)
//   prog_data      : programming-port write data
//   fetch_en       : a fetch is permitted this cycle
//   stall          : downstream stall, holds PC and every fetch output
//   redirect_valid : load the PC from redirect_pc (branch / jump)
//   redirect_pc    : redirect target word address
//   instr          : fetched instruction word (registered)
//   instr_valid    : instr / pc_out carry a valid fetch
//   pc_out         : word address of the word currently on instr
//   fault          : sticky out-of-range redirect flag, cleared only by reset
// -----------------------------------------------------------------------------
module instr_fetch_mem #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fault
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_A    = (ADDR_W + 1)'(DEPTH);

  // Address lies inside the populated part of the address space.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_A;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction storage
  // ---------------------------------------------------------------------------
  // Contents start at zero at time zero and survive reset, so a program loaded
  // before (or during) reset is still there when fetching starts.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  // NOTE: the memory deliberately has no reset branch; clearing every word
  // would turn a RAM into a flop array and would also wipe a freshly loaded
  // program. Writes are accepted regardless of reset or FSM state.
  always_ff @(posedge clk) begin
    if (prog_we && in_range(prog_addr)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch state
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] instr_q,  instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q,  valid_d;
  logic              fault_q,  fault_d;

  // Sequential successor of the PC, wrapping at the top of the populated
  // range rather than at 2**ADDR_W.
  logic [ADDR_W-1:0] pc_next_seq;
  // The word under the PC. It is sampled from the pre-edge array contents, so
  // a programming write to the same address in the same cycle is not seen
  // until a later fetch (read-before-write).
  logic [DATA_W-1:0] rd_word;
  // Set by the FSM when this cycle performs a fetch.
  logic              do_fetch;

  assign pc_next_seq = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
  assign rd_word     = mem_q[pc_q];

  always_comb begin
    // NOTE: every next-state signal gets a hold value before the case
    // statement, so paths that do not mention a register cannot infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    do_fetch = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        // The first fetch happens in the same cycle that leaves IDLE.
        if (fetch_en && !stall) begin
          do_fetch = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // A redirect wins over a stall: the target must be loaded even when
          // the consumer is frozen, otherwise the branch would be lost.
          if (in_range(redirect_pc)) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;          // one bubble, instr/pc_out held
          end else begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            instr_d = '0;
            state_d = ST_FAULT;
          end
        end else if (stall) begin
          // Everything holds via the defaults above.
        end else if (fetch_en) begin
          do_fetch = 1'b1;
        end else begin
          valid_d = 1'b0;
          instr_d = '0;
          state_d = ST_IDLE;
        end
      end

      ST_FAULT: begin
        // Terminal until reset; only the programming port stays live.
        valid_d = 1'b0;
        instr_d = '0;
        fault_d = 1'b1;
      end

      default: begin
        // Unreachable encoding: fall back to a quiet IDLE.
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (do_fetch) begin
      instr_d  = rd_word;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_next_seq;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC_A;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_mem
//
// Directed bench for instr_fetch_mem. A DEPTH=16 instance runs a table of
// per-cycle vectors; a DEPTH=12, RESET_PC=5 instance covers non-power-of-2
// wrap, ignored out-of-range writes and the sticky fault.
// -----------------------------------------------------------------------------
module tb_instr_fetch_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DEPTH = 16 instance
  // ---------------------------------------------------------------------------
  logic        rst, prog_we, fetch_en, stall, redirect_valid;
  logic [3:0]  prog_addr, redirect_pc;
  logic [31:0] prog_data;
  logic [31:0] instr;
  logic        instr_valid, fault;
  logic [3:0]  pc_out;

  instr_fetch_mem #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RESET_PC(0)) dut (
    .clk           (clk),
    .reset         (rst),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .fetch_en      (fetch_en),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .fault         (fault)
  );

  // ---------------------------------------------------------------------------
  // DEPTH = 12, RESET_PC = 5 instance
  // ---------------------------------------------------------------------------
  logic        b_rst, b_we, b_fe, b_st, b_rv;
  logic [3:0]  b_wa, b_rpc;
  logic [31:0] b_wd;
  logic [31:0] b_instr;
  logic        b_valid, b_fault;
  logic [3:0]  b_pc_out;

  instr_fetch_mem #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RESET_PC(5)) dut12 (
    .clk           (clk),
    .reset         (b_rst),
    .prog_we       (b_we),
    .prog_addr     (b_wa),
    .prog_data     (b_wd),
    .fetch_en      (b_fe),
    .stall         (b_st),
    .redirect_valid(b_rv),
    .redirect_pc   (b_rpc),
    .instr         (b_instr),
    .instr_valid   (b_valid),
    .pc_out        (b_pc_out),
    .fault         (b_fault)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst, fe, st, rv;
    logic [3:0]  rpc;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ei;
    logic [3:0]  ep;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, fe, st, rv, input logic [3:0] rpc,
                     input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic ev, input logic [31:0] ei,
                     input logic [3:0] ep, input logic ef);
    vec_t v;
    v.rst = r;  v.fe = fe; v.st = st; v.rv = rv; v.rpc = rpc;
    v.we  = we; v.wa = wa; v.wd = wd;
    v.ev  = ev; v.ei = ei; v.ep = ep; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string tag, input logic ev,
                         input logic [31:0] ei, input logic [3:0] ep,
                         input logic ef);
    check({tag, ".valid"}, 32'(b_valid), 32'(ev));
    check({tag, ".instr"}, b_instr, ei);
    check({tag, ".pc_out"}, 32'(b_pc_out), 32'(ep));
    check({tag, ".fault"}, 32'(b_fault), 32'(ef));
  endtask

  localparam logic [31:0] W0 = 32'h018D4820;
  localparam logic [31:0] W1 = 32'h01CE5020;
  localparam logic [31:0] W2 = 32'h01494022;
  localparam logic [31:0] WN = 32'hAAAA5555;

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    fetch_en = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    b_rst = 1'b1; b_we = 1'b0; b_wa = '0; b_wd = '0;
    b_fe = 1'b0; b_st = 1'b0; b_rv = 1'b0; b_rpc = '0;

    //   rst fe st rv rpc  we wa  wd     | v  instr pc f
    add(0, 0, 0, 0, 0,   0, 0, 0,       0, 0,  0, 0);  //  0 idle, no fetch
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W0, 0, 0);  //  1 first fetch
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W1, 1, 0);  //  2
    add(0, 1, 1, 0, 0,   0, 0, 0,       1, W1, 1, 0);  //  3 stall x3
    add(0, 1, 1, 0, 0,   0, 0, 0,       1, W1, 1, 0);  //  4
    add(0, 1, 1, 0, 0,   0, 0, 0,       1, W1, 1, 0);  //  5
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W2, 2, 0);  //  6 no skip/dup
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, 0,  3, 0);  //  7 zero-init word
    add(0, 1, 1, 1, 0,   0, 0, 0,       0, 0,  3, 0);  //  8 redirect in stall
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W0, 0, 0);  //  9 target word
    add(0, 1, 0, 0, 0,   1, 1, WN,      1, W1, 1, 0);  // 10 read-before-write
    add(0, 1, 0, 1, 1,   0, 0, 0,       0, W1, 1, 0);  // 11 redirect to 1
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, WN, 1, 0);  // 12 new word visible
    add(0, 1, 0, 1, 14,  0, 0, 0,       0, WN, 1, 0);  // 13 redirect to 14
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, 0,  14, 0); // 14
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, 0,  15, 0); // 15
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W0, 0, 0);  // 16 wrap
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, WN, 1, 0);  // 17
    add(0, 0, 0, 0, 0,   0, 0, 0,       0, 0,  1, 0);  // 18 back to idle
    add(0, 1, 1, 0, 0,   0, 0, 0,       0, 0,  1, 0);  // 19 stall in idle
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W2, 2, 0);  // 20 resume at pc 2
    add(1, 1, 1, 1, 9,   0, 0, 0,       0, 0,  0, 0);  // 21 reset wins
    add(0, 1, 0, 0, 0,   0, 0, 0,       1, W0, 0, 0);  // 22 pc = RESET_PC

    // Load the program while reset is asserted.
    tick();
    for (int k = 0; k < 3; k++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(k);
      prog_data = (k == 0) ? W0 : (k == 1) ? W1 : W2;
      tick();
    end
    prog_we = 1'b0;
    tick();
    check("reset.valid", 32'(instr_valid), 32'd0);
    check("reset.instr", instr, 32'd0);
    check("reset.pc_out", 32'(pc_out), 32'd0);
    check("reset.fault", 32'(fault), 32'd0);

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      fetch_en       = vecs[i].fe;
      stall          = vecs[i].st;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      prog_we        = vecs[i].we;
      prog_addr      = vecs[i].wa;
      prog_data      = vecs[i].wd;
      tick();
      check($sformatf("row%0d.valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d.instr", i), instr, vecs[i].ei);
      check($sformatf("row%0d.pc_out", i), 32'(pc_out), 32'(vecs[i].ep));
      check($sformatf("row%0d.fault", i), 32'(fault), 32'(vecs[i].ef));
    end
    fetch_en = 1'b0;

    // ---- DEPTH = 12 instance -------------------------------------------
    b_rst = 1'b0;
    b_we = 1'b1; b_wa = 4'd13; b_wd = 32'hDEADBEEF;   // beyond DEPTH: dropped
    tick();
    check_b("d12.oor_write", 0, 0, 0, 0);
    b_wa = 4'd11; b_wd = 32'h12345678;
    tick();
    b_we = 1'b0; b_fe = 1'b1;
    tick();
    check_b("d12.first", 1, 0, 5, 0);
    b_rv = 1'b1; b_rpc = 4'd11;
    tick();
    check_b("d12.redir11", 0, 0, 5, 0);
    b_rv = 1'b0;
    tick();
    check_b("d12.pc11", 1, 32'h12345678, 11, 0);
    tick();
    check_b("d12.wrap", 1, 0, 0, 0);
    b_rv = 1'b1; b_rpc = 4'd13;
    tick();
    check_b("d12.fault", 0, 0, 0, 1);
    b_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_b($sformatf("d12.sticky%0d", k), 0, 0, 0, 1);
    end
    b_rst = 1'b1;
    tick();
    check_b("d12.reset", 0, 0, 0, 0);
    b_rst = 1'b0;
    tick();
    check_b("d12.restart", 1, 0, 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

endmodule
